// File: rtl/shift_seq_pkg.sv
// +-------------------------------------------------------------------------+
// | shift_seq_pkg : op encodings and FSM state type for shift_sequencer      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

package shift_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_core.sv
// +-------------------------------------------------------------------------+
// | shift_core : WIDTH-bit register with load / SHL / SHR / ROR update       |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module shift_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // load wins over shift_en; a LOAD mode code with shift_en holds the value
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      case (mode)
        OP_SHL:  q <= {q[WIDTH-2:0], 1'b0};
        OP_SHR:  q <= {1'b0, q[WIDTH-1:1]};
        OP_ROR:  q <= {q[0], q[WIDTH-1:1]};
        default: q <= q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// +-------------------------------------------------------------------------+
// | shift_sequencer : command-driven FSM stepping a shift register one bit   |
// | per clock, with valid/ready intake and a one-cycle done pulse. Rev 1.0   |
// +-------------------------------------------------------------------------+
`default_nettype none

module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       op, op_nxt;
  logic             core_load;
  logic             core_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op    <= OP_LOAD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op    <= op_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_nxt     = op;
    core_load  = 1'b0;
    core_shift = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD) begin
            core_load = 1'b1;
            state_nxt = ST_DONE;
          end else if (cmd_amt == '0) begin
            state_nxt = ST_DONE;
          end else begin
            op_nxt    = cmd_op;
            cnt_nxt   = cmd_amt;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        core_shift = 1'b1;
        cnt_nxt    = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // mode tracks the latched op; shifts only ever happen in RUN
  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .shift_en (core_shift),
    .mode     (op),
    .d        (cmd_data),
    .q        (q)
  );

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// +-------------------------------------------------------------------------+
// | tb_shift_sequencer : directed table + hand sequences for shift_sequencer |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_amt = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] q;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [3:0] qtrace [0:15];

  typedef struct {
    logic [1:0] op;
    logic [2:0] amt;
    logic [3:0] data;
    logic [3:0] exp_q;
    int         exp_lat;
  } vec_t;

  vec_t vecs [0:15];
  int   nvec;

  shift_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] amt,
                              input logic [3:0] data, input logic [3:0] eq, input int lat);
    vec_t v;
    v.op = op; v.amt = amt; v.data = data; v.exp_q = eq; v.exp_lat = lat;
    return v;
  endfunction

  // Called right after a negedge: present a command, let it be taken on the
  // next posedge (E0) and return at the negedge following E0.
  task automatic issue(input logic [1:0] op, input logic [2:0] amt, input logic [3:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data;
    check("ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Samples at successive negedges starting after E0; sample k is after Ek.
  task automatic observe(output int lat, output int bcnt, output int dcnt);
    lat = -1; bcnt = 0; dcnt = 0;
    for (int k = 0; k < 16; k++) begin
      qtrace[k] = q;
      if (done && lat < 0) lat = k;
      if (done) dcnt++;
      if (!busy) break;
      bcnt++;
      @(negedge clk);
    end
    if (busy) check("observe_timeout", 1, 0);
  endtask

  initial begin
    int lat, bcnt, dcnt;

    // reset: two cycles
    @(negedge clk); @(negedge clk);
    check("reset_q", q, 4'b0000);
    check("reset_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;

    // reset while in DONE after a LOAD
    issue(2'b00, 3'd0, 4'b1011);
    check("load_q_before_abort", q, 4'b1011);
    check("in_done_before_abort", done, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_q", q, 4'b0000);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_done_next", done, 0);
    check("abort_busy_next", busy, 0);

    // table of commands, applied back to back from q=0000
    nvec = 0;
    vecs[nvec++] = mk(2'b00, 3'd0, 4'b1011, 4'b1011, 0);
    vecs[nvec++] = mk(2'b01, 3'd2, 4'b0000, 4'b1100, 2);
    vecs[nvec++] = mk(2'b00, 3'd0, 4'b1011, 4'b1011, 0);
    vecs[nvec++] = mk(2'b11, 3'd5, 4'b0000, 4'b1101, 5);
    vecs[nvec++] = mk(2'b10, 3'd0, 4'b0110, 4'b1101, 0);
    vecs[nvec++] = mk(2'b10, 3'd7, 4'b0000, 4'b0000, 7);
    vecs[nvec++] = mk(2'b00, 3'd0, 4'b1001, 4'b1001, 0);
    vecs[nvec++] = mk(2'b11, 3'd2, 4'b0000, 4'b0110, 2);
    vecs[nvec++] = mk(2'b11, 3'd4, 4'b0000, 4'b0110, 4);
    vecs[nvec++] = mk(2'b00, 3'd0, 4'b0001, 4'b0001, 0);
    vecs[nvec++] = mk(2'b01, 3'd3, 4'b1111, 4'b1000, 3);
    vecs[nvec++] = mk(2'b10, 3'd1, 4'b0000, 4'b0100, 1);
    vecs[nvec++] = mk(2'b11, 3'd1, 4'b0000, 4'b0010, 1);
    vecs[nvec++] = mk(2'b01, 3'd0, 4'b1111, 4'b0010, 0);
    vecs[nvec++] = mk(2'b00, 3'd0, 4'b1111, 4'b1111, 0);
    vecs[nvec++] = mk(2'b11, 3'd3, 4'b0000, 4'b1111, 3);

    for (int i = 0; i < nvec; i++) begin
      issue(vecs[i].op, vecs[i].amt, vecs[i].data);
      observe(lat, bcnt, dcnt);
      check("vec_latency", lat, vecs[i].exp_lat);
      check("vec_busy_cycles", bcnt, vecs[i].exp_lat + 1);
      check("vec_done_width", dcnt, 1);
      check("vec_q", q, vecs[i].exp_q);
      check("vec_ready_after", cmd_ready, 1);
    end

    // per-edge trace: SHL 2 from 1011
    issue(2'b00, 3'd0, 4'b1011); observe(lat, bcnt, dcnt);
    issue(2'b01, 3'd2, 4'b0000); observe(lat, bcnt, dcnt);
    check("shl2_e1", qtrace[1], 4'b0110);
    check("shl2_e2", qtrace[2], 4'b1100);

    // per-edge trace: SHR 7 from 1101 reaches zero at E4 and stays there
    issue(2'b00, 3'd0, 4'b1101); observe(lat, bcnt, dcnt);
    issue(2'b10, 3'd7, 4'b0000); observe(lat, bcnt, dcnt);
    check("shr7_e1", qtrace[1], 4'b0110);
    check("shr7_e3", qtrace[3], 4'b0001);
    check("shr7_e4", qtrace[4], 4'b0000);
    check("shr7_e7", qtrace[7], 4'b0000);

    // held LOAD during SHL 3 is not taken before EN+1
    issue(2'b00, 3'd0, 4'b1111); observe(lat, bcnt, dcnt);
    issue(2'b01, 3'd3, 4'b0000);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b0101;
    @(negedge clk); check("hold_e1", q, 4'b1110);
    @(negedge clk); check("hold_e2", q, 4'b1100);
    @(negedge clk); check("hold_e3", q, 4'b1000);
    check("hold_done_e3", done, 1);
    @(negedge clk);
    check("hold_not_taken_en1", q, 4'b1000);
    check("hold_ready_en1", cmd_ready, 1);
    @(negedge clk);
    check("hold_taken_q", q, 4'b0101);
    check("hold_taken_done", done, 1);
    cmd_valid = 1'b0;
    @(negedge clk);

    // abort SHL 3 with rst after E1, held LOAD taken once rst drops
    issue(2'b00, 3'd0, 4'b1111); observe(lat, bcnt, dcnt);
    issue(2'b01, 3'd3, 4'b0000);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b0101;
    @(negedge clk); check("abort2_e1", q, 4'b1110);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort2_q", q, 4'b0000);
    check("abort2_busy", busy, 0);
    check("abort2_done", done, 0);
    @(negedge clk);
    check("abort2_load_q", q, 4'b0101);
    check("abort2_load_done", done, 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort2_idle", cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
